instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage of the pipelined RV32I core. Owns the PC and issues in-order word reads to instruction memory.
//  Buffers returned words in a small queue and presents {instr, pc, pc+4} to decode via valid/ready.
//  Flushes on branch/jump redirects from execute and pre-flags opcodes outside the set the main decoder supports.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC of first fetch after reset
//  QDEPTH    2              queue entries = max requests outstanding (power of 2, >=2)
// PORTS
//  clk             in   1   core clock, all state on rising edge
//  reset           in   1   asynchronous, active-low reset
//  imem_req_valid  out  1   read request valid
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_req_addr   out  32  word address (= pc register, bits[1:0]=00)
//  imem_rsp_valid  in   1   read data valid; in request order; >=1 cycle after acceptance; no backpressure
//  imem_rsp_data   in   32  instruction word
//  redirect_valid  in   1   taken branch/jal/jalr from execute
//  redirect_pc     in   32  redirect target; bits[1:0] ignored (forced 00)
//  if_valid        out  1   decode-side entry valid
//  if_ready        in   1   decode accepts entry
//  if_instr        out  32  instruction word
//  if_pc           out  32  PC of if_instr
//  if_pc_plus4     out  32  if_pc + 4, mod 2^32
//  if_illegal      out  1   opcode not in {03,23,33,63,13,6F,67,37,17} (hex, 7-bit) or instr[1:0]!=11
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0, state=BOOT.
//   All outputs 0; imem_req_addr=RESET_PC.
//  FSM: BOOT -> RUN unconditionally one cycle after reset release; first request is in the following cycle.
//   RUN -> FLUSH on redirect with in-flight requests (outstanding>0 after that cycle's rsp).
//   FLUSH -> RUN when drop_cnt reaches 0.
//  Issue (RUN only): imem_req_valid = (outstanding + occupancy < QDEPTH) && !redirect_valid.
//   Handshake valid&&ready: outstanding++, pc += 4 (wraps at 2^32).
//   Valid/addr hold stable until ready; the only permitted withdrawal is a redirect cycle.
//  Response: if drop_cnt>0, discard and drop_cnt--.
//   Else push {data, pc_of_req}; pc_of_req is tracked by a tag/PC FIFO or by queue-tail PC + 4.
//   outstanding-- in both cases. Credit rule ensures push never overflows.
//  Output: if_* driven from queue head (registered). Response at cycle N -> if_valid at N+1 at the earliest.
//   Pop on if_valid&&if_ready. Simultaneous push and pop on a full queue is legal.
//  Redirect (highest priority), effective next cycle:
//   - pc=redirect_pc&~3;
//   - queue cleared;
//   - drop_cnt = outstanding after that cycle's rsp and req;
//   - if_valid=0;
//   - no request issued in the redirect cycle.
//   An if handshake in the redirect cycle completes; decode squashes it.
//   An rsp in the redirect cycle is discarded.
//   A redirect during FLUSH reloads pc and keeps drop_cnt; nothing was issued during FLUSH.
//  Back-to-back redirects: the last one wins. Sustained throughput is 1 instr/cycle with 1-cycle memory and QDEPTH>=2.
//  Reset mid-operation: immediate return to reset values. In-flight memory responses after release are the memory's reset problem.
// STRUCTURE
//  Shared header riscv_defs.vh: opcode constants OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_ITYPE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC.
//   main_decoder and this block both use them; the legality check is a single function there.
//  FSM state encodings are localparams, local to this block.
//  One sub-module: fetch_queue. It is a sync FIFO {instr,pc}, QDEPTH entries, with push/pop/clear/count and async active-low reset.
// TESTING
//  1. Reset release, mem always ready, 1-cycle rsp, if_ready=1:
//     req addrs 0,4,8..; if_pc 0,4,8 one per cycle; if_pc_plus4 = if_pc+4.
//  2. if_ready=0 for 10 cycles:
//     exactly QDEPTH requests outstanding, then imem_req_valid=0. No loss and no reorder on release.
//  3. Redirect to 0x100 while 2 in-flight (3-cycle memory):
//     both rsps dropped; next req addr 0x100; first if_pc=0x100; FLUSH->RUN observed.
//  4. redirect_pc=0x0000_0203:
//     fetch from 0x200. Same-cycle rsp_valid is discarded.
//  5. Feed 0x00000013 (nop), 0x0000007F, 0x00000012, 0x000000B7:
//     if_illegal = 0, 1, 1, 0.
//  6. pc=0xFFFF_FFFC fetch: next addr 0x0, if_pc_plus4=0x0.
//     Assert reset mid-burst: all outputs 0 asynchronously; restart at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage types: RV32I major opcodes, queue entry layout
// and the opcode legality check used by fetch and the main decoder.
package instr_fetch_unit_pkg;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_RTYPE  = 7'h33;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_ITYPE  = 7'h13;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fq_entry_t;

    function automatic logic is_illegal(input logic [31:0] instr);
        logic ok;
        case (instr[6:0])
            OP_LOAD, OP_STORE, OP_RTYPE,
            OP_BRANCH, OP_ITYPE, OP_JAL,
            OP_JALR, OP_LUI, OP_AUIPC: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return !(ok && (instr[1:0] == 2'b11));
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: imem request/response, execute redirect and
// the decode-side valid/ready bundle.
interface instr_fetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        if_illegal;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output if_valid, if_instr, if_pc,
        output if_pc_plus4, if_illegal,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  if_valid, if_instr, if_pc,
        input  if_pc_plus4, if_illegal,
        output if_ready
    );

endinterface

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Sync FIFO of {instr, pc} between imem responses and decode.
// DEPTH must be a power of two so the pointers wrap naturally.
import instr_fetch_unit_pkg::*;

module instr_fetch_unit_fetch_queue #(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  fq_entry_t push_data,
    input  logic      pop,
    input  logic      clear,
    output fq_entry_t head,
    output logic [AW:0] count
);

    fq_entry_t     mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push)
                           - (AW+1)'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: owns the PC, issues credit-limited imem reads,
// queues returned words for decode and flushes on execute redirects.
import instr_fetch_unit_pkg::*;

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input logic              clk,
    input logic              reset,
    instr_fetch_unit_if.master fetch
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CW + 1;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [31:0]   pc;
    logic [31:0]   pc_nx;
    logic [31:0]   rsp_pc;
    logic [31:0]   rsp_pc_nx;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] out_nx;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] drop_nx;
    logic [CW-1:0] count;
    logic [SW-1:0] credit;
    logic [31:0]   target;
    logic          q_valid;
    logic          pop;
    logic          push;
    logic          req_fire;
    logic          drop_rsp;
    fq_entry_t     head;
    fq_entry_t     push_data;

    assign target  = {fetch.redirect_pc[31:2], 2'b00};
    assign q_valid = (count != '0);
    assign pop     = q_valid && fetch.if_ready;

    // A pop this cycle frees its slot before any new response can land,
    // which is what sustains one instruction per cycle at QDEPTH=2.
    assign credit = SW'(outstanding) + SW'(count) - SW'(pop);

    assign fetch.imem_req_valid = (state == RUN)
                               && (credit < SW'(QDEPTH))
                               && !fetch.redirect_valid;
    assign fetch.imem_req_addr  = pc;

    assign req_fire = fetch.imem_req_valid && fetch.imem_req_ready;
    assign drop_rsp = (drop_cnt != '0) || fetch.redirect_valid;
    assign push     = fetch.imem_rsp_valid && !drop_rsp;

    assign push_data = '{instr: fetch.imem_rsp_data, pc: rsp_pc};

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        rsp_pc_nx = rsp_pc;
        drop_nx   = drop_cnt;
        out_nx    = outstanding + CW'(req_fire)
                                - CW'(fetch.imem_rsp_valid);
        if (fetch.imem_rsp_valid && (drop_cnt != '0))
            drop_nx = drop_cnt - CW'(1);
        if (req_fire)
            pc_nx = pc + 32'd4;
        if (push)
            rsp_pc_nx = rsp_pc + 32'd4;
        // Everything still in flight after this cycle is stale.
        if (fetch.redirect_valid) begin
            pc_nx     = target;
            rsp_pc_nx = target;
            drop_nx   = out_nx;
        end
        unique case (state)
            BOOT:    state_nx = RUN;
            RUN:     if (drop_nx != '0) state_nx = FLUSH;
            FLUSH:   if (drop_nx == '0) state_nx = RUN;
            default: state_nx = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            rsp_pc      <= rsp_pc_nx;
            outstanding <= out_nx;
            drop_cnt    <= drop_nx;
        end
    end

    instr_fetch_unit_fetch_queue #(
        .DEPTH(QDEPTH)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .clear    (fetch.redirect_valid),
        .head     (head),
        .count    (count)
    );

    assign fetch.if_valid    = q_valid;
    assign fetch.if_instr    = q_valid ? head.instr : '0;
    assign fetch.if_pc       = q_valid ? head.pc : '0;
    assign fetch.if_pc_plus4 = q_valid ? head.pc + 32'd4 : '0;
    assign fetch.if_illegal  = q_valid && is_illegal(head.instr);

endmodule
